// File: rtl/beehive_rx_frame_buffer_pkg.sv
// Shared types and widths for the Beehive RX frame buffer.
// Default interface widths apply when the surrounding build has not defined them.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif

package beehive_rx_frame_buffer_pkg;

    localparam int MTU_W = `MTU_SIZE_W;
    localparam int PAD_W = $clog2(`MAC_INTERFACE_W / 8);

    typedef struct packed {
        logic [MTU_W-1:0] size;
    } rx_meta_t;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        DROP
    } wr_state_e;

endpackage

// File: rtl/beehive_rx_frame_buffer_rx_serializer.sv
// Wide-to-narrow stage: holds one AXIS beat and emits it as OUT_DATA_W lines,
// lowest sub-word first, skipping empty tail sub-words on the last beat.
module rx_serializer #(
    parameter int IN_DATA_W  = 512,
    parameter int OUT_DATA_W = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    input  logic [IN_DATA_W-1:0]    in_data,
    input  logic [IN_DATA_W/8-1:0]  in_keep,
    input  logic                    in_last,
    input  logic                    in_bad,
    output logic                    in_rdy,
    output logic                    out_val,
    output logic [OUT_DATA_W-1:0]   out_data,
    output logic [OUT_DATA_W/8-1:0] out_keep,
    output logic                    out_last,
    output logic                    out_bad
);

    localparam int RATIO = IN_DATA_W / OUT_DATA_W;
    localparam int OUT_B = OUT_DATA_W / 8;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                   busy;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       last_idx;
    logic [IDX_W-1:0]       in_last_idx;
    logic [IN_DATA_W-1:0]   beat_data;
    logic [IN_DATA_W/8-1:0] beat_keep;
    logic                   beat_last;
    logic                   beat_bad;
    logic                   final_sub;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_last_idx = IDX_W'(RATIO - 1);
        if (in_last) begin
            in_last_idx = '0;
            for (int i = 0; i < RATIO; i++) begin
                if (|in_keep[i*OUT_B +: OUT_B]) in_last_idx = IDX_W'(i);
            end
        end
    end

    assign final_sub = (idx == last_idx);
    // A new beat may load while the final sub-word of the current one is leaving.
    assign in_rdy    = !rst && (!busy || final_sub);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            idx      <= '0;
            last_idx <= '0;
        end else if (in_val && in_rdy) begin
            busy     <= 1'b1;
            idx      <= '0;
            last_idx <= in_last_idx;
        end else if (busy) begin
            if (final_sub) busy <= 1'b0;
            else           idx  <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_val && in_rdy) begin
            beat_data <= in_data;
            beat_keep <= in_keep;
            beat_last <= in_last;
            beat_bad  <= in_bad;
        end
    end

    assign out_val  = busy;
    assign out_data = beat_data[int'(idx)*OUT_DATA_W +: OUT_DATA_W];
    assign out_keep = beat_keep[int'(idx)*OUT_B +: OUT_B];
    assign out_last = beat_last && final_sub;
    assign out_bad  = beat_bad;

endmodule

// File: rtl/beehive_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: narrows AXIS beats to Beehive lines and only
// exposes whole, good frames; bad, oversize or no-space frames are dropped and counted.
module beehive_rx_frame_buffer
    import beehive_rx_frame_buffer_pkg::*;
#(
    parameter int IN_DATA_W   = 512,
    parameter int IN_USER_W   = 1,
    parameter int OUT_DATA_W  = `MAC_INTERFACE_W,
    parameter int DATA_DEPTH  = 256,
    parameter int META_DEPTH  = 16,
    parameter int MAX_FRAME_B = 9018,
    parameter int FLIP_BYTES  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   app_axis_sync_rx_tvalid,
    input  logic [IN_DATA_W-1:0]   app_axis_sync_rx_tdata,
    input  logic [IN_DATA_W/8-1:0] app_axis_sync_rx_tkeep,
    input  logic                   app_axis_sync_rx_tlast,
    input  logic [IN_USER_W-1:0]   app_axis_sync_rx_tuser,
    output logic                   app_axis_sync_rx_tready,
    output logic                   convert_dst_rx_val,
    output logic [OUT_DATA_W-1:0]  convert_dst_rx_data,
    output logic                   convert_dst_rx_startframe,
    output logic [MTU_W-1:0]       convert_dst_rx_frame_size,
    output logic                   convert_dst_rx_endframe,
    output logic [PAD_W-1:0]       convert_dst_rx_padbytes,
    input  logic                   dst_convert_rx_rdy,
    output logic [31:0]            rx_frames_cnt,
    output logic [31:0]            rx_drop_cnt
);

    localparam int OUT_B      = OUT_DATA_W / 8;
    localparam int CNT_W      = $clog2(OUT_B + 1);
    localparam int LINE_SHIFT = $clog2(OUT_B);
    localparam int AW         = $clog2(DATA_DEPTH);
    localparam int MW         = $clog2(META_DEPTH);

    if (IN_DATA_W % OUT_DATA_W != 0) begin : g_bad_width
        $error("IN_DATA_W must be a multiple of OUT_DATA_W");
    end

    function automatic logic [OUT_DATA_W-1:0] flip_line(input logic [OUT_DATA_W-1:0] d);
        logic [OUT_DATA_W-1:0] r;
        for (int j = 0; j < OUT_B; j++) r[(OUT_B-1-j)*8 +: 8] = d[j*8 +: 8];
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [OUT_B-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_B; i++) c = c + CNT_W'(k[i]);
        return c;
    endfunction

    logic                  s_val, s_last, s_bad;
    logic [OUT_DATA_W-1:0] s_data;
    logic [OUT_B-1:0]      s_keep;

    rx_serializer #(
        .IN_DATA_W  (IN_DATA_W),
        .OUT_DATA_W (OUT_DATA_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .in_val   (app_axis_sync_rx_tvalid),
        .in_data  (app_axis_sync_rx_tdata),
        .in_keep  (app_axis_sync_rx_tkeep),
        .in_last  (app_axis_sync_rx_tlast),
        .in_bad   (app_axis_sync_rx_tuser[0]),
        .in_rdy   (app_axis_sync_rx_tready),
        .out_val  (s_val),
        .out_data (s_data),
        .out_keep (s_keep),
        .out_last (s_last),
        .out_bad  (s_bad)
    );

    // Line stage. Flipping each narrowed line equals flipping the whole beat and
    // walking it from the top, so frame bytes stay in order across lines.
    logic                  l_val, l_last, l_bad;
    logic [OUT_DATA_W-1:0] l_data;
    logic [CNT_W-1:0]      l_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            l_val <= 1'b0;
        end else begin
            l_val  <= s_val;
            l_data <= (FLIP_BYTES != 0) ? flip_line(s_data) : s_data;
            l_cnt  <= popcount(s_keep);
            l_last <= s_last;
            l_bad  <= s_bad;
        end
    end

    // Write side: speculative pointer runs ahead of the committed one until tlast.
    wr_state_e             state;
    logic [AW:0]           wr_spec, wr_commit, rd;
    logic [MW:0]           meta_wr, meta_rd, meta_f;
    logic [MTU_W-1:0]      byte_cnt, cnt_next, cnt_base;
    logic [MTU_W:0]        cnt_sum;
    logic                  data_full, meta_full, oversize, line_err;
    logic                  do_write, do_commit, do_drop;
    logic [OUT_DATA_W-1:0] data_mem [DATA_DEPTH];
    rx_meta_t              meta_mem [META_DEPTH];

    assign data_full = (wr_spec[AW] != rd[AW]) && (wr_spec[AW-1:0] == rd[AW-1:0]);
    assign meta_full = (meta_wr[MW] != meta_rd[MW]) && (meta_wr[MW-1:0] == meta_rd[MW-1:0]);
    assign cnt_base  = (state == WR) ? byte_cnt : '0;
    assign cnt_sum   = {1'b0, cnt_base} + (MTU_W+1)'(l_cnt);
    assign cnt_next  = cnt_sum[MTU_W] ? '1 : cnt_sum[MTU_W-1:0];
    assign oversize  = ({1'b0, cnt_next} > (MTU_W+1)'(MAX_FRAME_B));
    assign line_err  = data_full || oversize || (state == IDLE && meta_full);
    assign do_write  = l_val && (state != DROP) && !line_err;
    assign do_commit = do_write && l_last && !l_bad;
    assign do_drop   = l_val && (state != DROP) && (line_err || (l_last && l_bad));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_spec       <= '0;
            wr_commit     <= '0;
            byte_cnt      <= '0;
            meta_wr       <= '0;
            rx_frames_cnt <= '0;
            rx_drop_cnt   <= '0;
        end else begin
            if (do_drop) begin
                wr_spec <= wr_commit;
                if (~&rx_drop_cnt) rx_drop_cnt <= rx_drop_cnt + 32'd1;
            end else if (do_write) begin
                wr_spec  <= wr_spec + 1'b1;
                byte_cnt <= cnt_next;
            end
            if (do_commit) begin
                wr_commit <= wr_spec + 1'b1;
                meta_wr   <= meta_wr + 1'b1;
                if (~&rx_frames_cnt) rx_frames_cnt <= rx_frames_cnt + 32'd1;
            end
            if (l_val) begin
                case (state)
                    IDLE, WR: state <= l_last ? IDLE : (line_err ? DROP : WR);
                    DROP:     if (l_last) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_write)  data_mem[wr_spec[AW-1:0]] <= l_data;
        if (do_commit) meta_mem[meta_wr[MW-1:0]] <= '{size: cnt_next};
    end

    // Read side: a fetch cursor fills the output register; rd and meta_rd only
    // move on consumer transfers, so space is freed exactly when data leaves.
    logic [AW-1:0]    f_ptr;
    logic [MTU_W-1:0] f_line, f_lines_m1;
    rx_meta_t         f_meta;
    logic             fetch_avail, f_end, out_take, load;
    logic [PAD_W-1:0] f_pad;

    assign fetch_avail = (meta_f != meta_wr);
    assign f_meta      = meta_mem[meta_f[MW-1:0]];
    assign f_lines_m1  = (f_meta.size == '0) ? '0 : (f_meta.size - 1'b1) >> LINE_SHIFT;
    assign f_end       = (f_line == f_lines_m1);
    assign f_pad       = PAD_W'(~f_meta.size + 1'b1);
    assign out_take    = convert_dst_rx_val && dst_convert_rx_rdy;
    assign load        = fetch_avail && (!convert_dst_rx_val || dst_convert_rx_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            convert_dst_rx_val        <= 1'b0;
            convert_dst_rx_startframe <= 1'b0;
            convert_dst_rx_endframe   <= 1'b0;
            convert_dst_rx_frame_size <= '0;
            convert_dst_rx_padbytes   <= '0;
            rd                        <= '0;
            meta_rd                   <= '0;
            f_ptr                     <= '0;
            f_line                    <= '0;
            meta_f                    <= '0;
        end else begin
            if (out_take) begin
                rd <= rd + 1'b1;
                if (convert_dst_rx_endframe) meta_rd <= meta_rd + 1'b1;
            end
            if (load) begin
                convert_dst_rx_val        <= 1'b1;
                convert_dst_rx_startframe <= (f_line == '0);
                convert_dst_rx_frame_size <= (f_line == '0) ? f_meta.size : '0;
                convert_dst_rx_endframe   <= f_end;
                convert_dst_rx_padbytes   <= f_end ? f_pad : '0;
                f_ptr                     <= f_ptr + 1'b1;
                f_line                    <= f_end ? '0 : f_line + 1'b1;
                if (f_end) meta_f <= meta_f + 1'b1;
            end else if (out_take) begin
                convert_dst_rx_val        <= 1'b0;
                convert_dst_rx_startframe <= 1'b0;
                convert_dst_rx_endframe   <= 1'b0;
                convert_dst_rx_frame_size <= '0;
                convert_dst_rx_padbytes   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) convert_dst_rx_data <= data_mem[f_ptr];
    end

endmodule

// File: tb/tb_beehive_rx_frame_buffer.sv
// Directed bench for beehive_rx_frame_buffer: byte-accurate frame model, drop paths,
// reset behaviour and last-beat-to-valid latency.
module tb_beehive_rx_frame_buffer;
    import beehive_rx_frame_buffer_pkg::*;

    localparam int IN_W  = 512;
    localparam int OUT_W = 256;
    localparam int IN_B  = IN_W / 8;
    localparam int OUT_B = OUT_W / 8;
    localparam int RATIO = IN_W / OUT_W;

    logic             clk, rst;
    logic             tvalid, tlast, tready;
    logic [IN_W-1:0]  tdata;
    logic [IN_B-1:0]  tkeep;
    logic [0:0]       tuser;
    logic             val, start, fin, rdy;
    logic [OUT_W-1:0] data;
    logic [MTU_W-1:0] fsize;
    logic [PAD_W-1:0] pad;
    logic [31:0]      frames_cnt, drop_cnt;

    beehive_rx_frame_buffer #(
        .IN_DATA_W  (IN_W),
        .IN_USER_W  (1),
        .OUT_DATA_W (OUT_W),
        .DATA_DEPTH (8),
        .META_DEPTH (2)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .app_axis_sync_rx_tvalid   (tvalid),
        .app_axis_sync_rx_tdata    (tdata),
        .app_axis_sync_rx_tkeep    (tkeep),
        .app_axis_sync_rx_tlast    (tlast),
        .app_axis_sync_rx_tuser    (tuser),
        .app_axis_sync_rx_tready   (tready),
        .convert_dst_rx_val        (val),
        .convert_dst_rx_data       (data),
        .convert_dst_rx_startframe (start),
        .convert_dst_rx_frame_size (fsize),
        .convert_dst_rx_endframe   (fin),
        .convert_dst_rx_padbytes   (pad),
        .dst_convert_rx_rdy        (rdy),
        .rx_frames_cnt             (frames_cnt),
        .rx_drop_cnt               (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             start;
        logic             fin;
        logic [MTU_W-1:0] size;
        logic [PAD_W-1:0] pad;
    } line_t;

    line_t got_q[$];
    line_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    max_wait;
    int    lat;

    // Transfers are recorded on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        if (!rst && val && rdy) got_q.push_back({data, start, fin, fsize, pad});
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int seed, input int i, input int n);
        if (i >= n) return 8'h00;
        return 8'((seed * 37 + i * 5 + 3) & 255);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic [IN_B-1:0] k,
                             input logic l, input logic u);
        int w;
        w      = 0;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = u;
        while (!tready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w > max_wait) max_wait = w;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    // Sends an n-byte frame; beat_limit > 0 stops after that many beats.
    task automatic send_frame(input int n, input logic u, input int seed, input int beat_limit);
        int nb;
        logic [IN_W-1:0] d;
        logic [IN_B-1:0] k;
        nb = (n + IN_B - 1) / IN_B;
        for (int b = 0; b < nb; b++) begin
            if (beat_limit > 0 && b >= beat_limit) break;
            for (int j = 0; j < IN_B; j++) begin
                d[j*8 +: 8] = fb(seed, b * IN_B + j, n);
                k[j]        = (b * IN_B + j < n);
            end
            send_beat(d, k, b == nb - 1, (b == nb - 1) ? u : 1'b0);
        end
    endtask

    // Expected lines: bytes in frame order, byte 0 of each line in its top byte lane.
    task automatic expect_frame(input int n, input int seed);
        int    nl;
        line_t ln;
        nl = (n + OUT_B - 1) / OUT_B;
        for (int l = 0; l < nl; l++) begin
            for (int j = 0; j < OUT_B; j++) ln.data[(OUT_B-1-j)*8 +: 8] = fb(seed, l * OUT_B + j, n);
            ln.start = (l == 0);
            ln.fin   = (l == nl - 1);
            ln.size  = (l == 0) ? MTU_W'(n) : '0;
            ln.pad   = (l == nl - 1) ? PAD_W'(nl * OUT_B - n) : '0;
            exp_q.push_back(ln);
        end
    endtask

    task automatic compare_lines(input string tag);
        check({tag, " line count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s l%0d data", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s l%0d start", tag, i), got_q[i].start, exp_q[i].start);
            check($sformatf("%s l%0d end", tag, i), got_q[i].fin, exp_q[i].fin);
            check($sformatf("%s l%0d size", tag, i), got_q[i].size, exp_q[i].size);
            check($sformatf("%s l%0d pad", tag, i), got_q[i].pad, exp_q[i].pad);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst    = 1'b1;
        tvalid = 1'b0;
        tick(1);
        check({tag, " tready in reset"}, tready, 1'b0);
        rst = 1'b0;
        #1;
        check({tag, " tready after reset"}, tready, 1'b1);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        tdata = '0; tkeep = '0; rdy = 1'b0;
        tick(2);
        do_reset("init");
        check("init val", val, 1'b0);
        check("init start", start, 1'b0);
        check("init end", fin, 1'b0);
        check("init pad", pad, '0);
        check("init size", fsize, '0);
        check("init frames", frames_cnt, 32'd0);
        check("init drops", drop_cnt, 32'd0);

        // 1: single-beat 64B frame and last-beat-to-valid latency
        rdy = 1'b1;
        send_frame(64, 1'b0, 1, 0);
        lat = 0;
        while (!val && lat < 20) begin
            tick(1);
            lat++;
        end
        check("t1 latency", lat, RATIO + 2);
        expect_frame(64, 1);
        tick(20);
        compare_lines("t1");
        check("t1 frames", frames_cnt, 32'd1);
        check("t1 drops", drop_cnt, 32'd0);

        // 2: 65B frame, empty tail sub-word suppressed, pad on last line
        do_reset("t2");
        rdy = 1'b1;
        send_frame(65, 1'b0, 2, 0);
        expect_frame(65, 2);
        tick(20);
        compare_lines("t2");
        check("t2 frames", frames_cnt, 32'd1);

        // 3: tuser error on tlast, then a good frame
        do_reset("t3");
        rdy = 1'b1;
        send_frame(128, 1'b1, 3, 0);
        tick(20);
        check("t3 no lines", got_q.size(), 0);
        check("t3 drops", drop_cnt, 32'd1);
        send_frame(64, 1'b0, 4, 0);
        expect_frame(64, 4);
        tick(20);
        compare_lines("t3");
        check("t3 frames", frames_cnt, 32'd1);
        check("t3 drops after", drop_cnt, 32'd1);

        // 4: 10-line frame into 8-line buffer, then an exactly-full 8-line frame
        do_reset("t4");
        rdy = 1'b0;
        max_wait = 0;
        send_frame(300, 1'b0, 5, 0);
        tick(20);
        check("t4 val", val, 1'b0);
        check("t4 drops", drop_cnt, 32'd1);
        check("t4 frames", frames_cnt, 32'd0);
        check("t4 max tready wait", max_wait, RATIO - 1);
        send_frame(256, 1'b0, 6, 0);
        tick(20);
        check("t4 full frames", frames_cnt, 32'd1);
        check("t4 full drops", drop_cnt, 32'd1);
        rdy = 1'b1;
        expect_frame(256, 6);
        tick(30);
        compare_lines("t4");

        // 5: three frames against a two-entry meta FIFO
        do_reset("t5");
        rdy = 1'b0;
        max_wait = 0;
        send_frame(64, 1'b0, 7, 0);
        send_frame(64, 1'b0, 8, 0);
        send_frame(64, 1'b0, 9, 0);
        tick(20);
        check("t5 drops", drop_cnt, 32'd1);
        check("t5 frames", frames_cnt, 32'd2);
        check("t5 max tready wait", max_wait, RATIO - 1);
        check("t5 head val", val, 1'b1);
        check("t5 head size", fsize, 64);
        rdy = 1'b1;
        expect_frame(64, 7);
        expect_frame(64, 8);
        tick(20);
        compare_lines("t5");
        check("t5 drained val", val, 1'b0);

        // 6: reset with a committed frame and a partial frame in flight
        do_reset("t6");
        rdy = 1'b0;
        send_frame(64, 1'b0, 10, 0);
        send_frame(128, 1'b0, 11, 1);
        tick(3);
        check("t6 pre-reset val", val, 1'b1);
        rst = 1'b1;
        tick(1);
        check("t6 val", val, 1'b0);
        check("t6 start", start, 1'b0);
        check("t6 end", fin, 1'b0);
        check("t6 pad", pad, '0);
        check("t6 size", fsize, '0);
        check("t6 tready in reset", tready, 1'b0);
        check("t6 frames cleared", frames_cnt, 32'd0);
        rst = 1'b0;
        #1;
        check("t6 tready after reset", tready, 1'b1);
        got_q.delete();
        rdy = 1'b1;
        send_frame(64, 1'b0, 12, 0);
        expect_frame(64, 12);
        tick(20);
        compare_lines("t6");
        check("t6 frames", frames_cnt, 32'd1);
        check("t6 drops", drop_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
